// File: rtl/qam16_pkg.sv
// Shared constants and types for the 16-QAM demapper: Gray levels, defaults, serializer states.
package qam16_pkg;

  localparam int          OSR_DEF = 8;
  localparam int unsigned THR_DEF = 4096;

  // Per-axis Gray code for the four amplitude levels
  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/qam_slicer.sv
// Combinational single-axis slicer: signed sample to 2-bit Gray level, zero latency.
module qam_slicer
  import qam16_pkg::*;
#(
  parameter int          DW  = 19,
  parameter int unsigned THR = THR_DEF
) (
  input  logic signed [DW-1:0] x,
  output logic        [1:0]    gray
);

  // One guard bit so -THR and the most negative input compare without wrap
  localparam logic signed [DW:0] POS = (DW+1)'(THR);
  localparam logic signed [DW:0] NEG = -POS;

  logic signed [DW:0] xe;

  assign xe = {x[DW-1], x};

  always_comb begin
    gray = GRAY_P3;
    if (xe < NEG) begin
      gray = GRAY_M3;
    end else if (xe[DW]) begin
      gray = GRAY_M1;
    end else if (xe < POS) begin
      gray = GRAY_P1;
    end
  end

endmodule

// File: rtl/qam_demap.sv
// 16-QAM symbol decision, Gray demap and 4-bit serializer; code_valid 2 cycles after capture.
// Serial output uses valid/ready with a one-entry holding buffer; codes arriving with it full are dropped.
module qam_demap
  import qam16_pkg::*;
#(
  parameter int          OSR = OSR_DEF,
  parameter int          DW  = 19,
  parameter int unsigned THR = THR_DEF
) (
  input  logic                 CLK,
  input  logic                 Rst_n,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] din_q,
  input  logic                 din_valid,
  input  logic        [3:0]    sample_phase,
  output logic        [3:0]    code_out,
  output logic                 code_valid,
  output logic                 bit_out,
  output logic                 bit_valid,
  input  logic                 bit_ready,
  input  logic                 ovf_clr,
  output logic                 overflow
);

  localparam logic [3:0] LAST_PHASE = 4'(OSR - 1);

  logic [3:0]           phase;
  logic                 hit;
  logic                 cap_vld;
  logic signed [DW-1:0] cap_i;
  logic signed [DW-1:0] cap_q;
  logic [1:0]           gray_i;
  logic [1:0]           gray_q;

  // phase never reaches values >= OSR, so an out-of-range sample_phase never hits
  assign hit = din_valid && (phase == sample_phase);

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      phase   <= '0;
      cap_vld <= 1'b0;
      cap_i   <= '0;
      cap_q   <= '0;
    end else begin
      cap_vld <= hit;
      if (din_valid) begin
        phase <= (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;
      end
      if (hit) begin
        cap_i <= din_i;
        cap_q <= din_q;
      end
    end
  end

  qam_slicer #(.DW(DW), .THR(THR)) u_slice_i (.x(cap_i), .gray(gray_i));
  qam_slicer #(.DW(DW), .THR(THR)) u_slice_q (.x(cap_q), .gray(gray_q));

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      code_out   <= '0;
      code_valid <= 1'b0;
    end else begin
      code_valid <= cap_vld;
      if (cap_vld) begin
        code_out <= {gray_i, gray_q};
      end
    end
  end

  ser_state_t state, state_n;
  logic [3:0] shreg, shreg_n;
  logic [3:0] hold, hold_n;
  logic [1:0] bcnt, bcnt_n;
  logic       full, full_n;
  logic       take;
  logic       last;
  logic       drop;

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= S_IDLE;
      shreg <= '0;
      hold  <= '0;
      bcnt  <= '0;
      full  <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      hold  <= hold_n;
      bcnt  <= bcnt_n;
      full  <= full_n;
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    hold_n  = hold;
    bcnt_n  = bcnt;
    full_n  = full;
    drop    = 1'b0;
    take    = (state == S_SHIFT) && bit_ready;
    last    = take && (bcnt == 2'd3);
    case (state)
      S_IDLE: begin
        if (code_valid) begin
          shreg_n = code_out;
          bcnt_n  = 2'd0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (take && !last) begin
          shreg_n = {shreg[2:0], 1'b0};
          bcnt_n  = bcnt + 2'd1;
        end
        if (last) begin
          // Refill from the buffer, else from the arriving code, so no bubble appears
          bcnt_n = 2'd0;
          if (full) begin
            shreg_n = hold;
            full_n  = code_valid;
            if (code_valid) begin
              hold_n = code_out;
            end
          end else if (code_valid) begin
            shreg_n = code_out;
          end else begin
            state_n = S_IDLE;
          end
        end else if (code_valid) begin
          if (!full) begin
            hold_n = code_out;
            full_n = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bit_valid = (state == S_SHIFT);
  assign bit_out   = bit_valid & shreg[3];

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qam_demap.sv
// Bench for qam_demap: OSR=8 and OSR=4 instances share stimulus; a queue-level model is checked every cycle.
module tb_qam_demap;

  logic               CLK;
  logic               Rst_n;
  logic signed [18:0] din_i;
  logic signed [18:0] din_q;
  logic               din_valid;
  logic [3:0]         sample_phase;
  logic               bit_ready;
  logic               ovf_clr;

  logic [3:0] code_o [2];
  logic       cv [2];
  logic       bo [2];
  logic       bv [2];
  logic       ov [2];

  qam_demap #(.OSR(8), .DW(19), .THR(4096)) u_dut8 (
    .CLK(CLK), .Rst_n(Rst_n), .din_i(din_i), .din_q(din_q), .din_valid(din_valid),
    .sample_phase(sample_phase), .code_out(code_o[0]), .code_valid(cv[0]),
    .bit_out(bo[0]), .bit_valid(bv[0]), .bit_ready(bit_ready),
    .ovf_clr(ovf_clr), .overflow(ov[0])
  );

  qam_demap #(.OSR(4), .DW(19), .THR(4096)) u_dut4 (
    .CLK(CLK), .Rst_n(Rst_n), .din_i(din_i), .din_q(din_q), .din_valid(din_valid),
    .sample_phase(sample_phase), .code_out(code_o[1]), .code_valid(cv[1]),
    .bit_out(bo[1]), .bit_valid(bv[1]), .bit_ready(bit_ready),
    .ovf_clr(ovf_clr), .overflow(ov[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Specification-level slicer + Gray map
  function automatic logic [1:0] slice(input int x);
    if (x < -4096) return 2'b00;
    else if (x < 0) return 2'b01;
    else if (x < 4096) return 2'b11;
    else return 2'b10;
  endfunction

  // Model: sample index, 2-stage code pipeline, queue of up to 2 pending codes
  int         mcnt [2];
  bit         v1 [2], v2 [2];
  logic [3:0] c1 [2], c2 [2];
  logic [3:0] mqa [2][2];
  int         mqn [2];
  int         mbit [2];
  bit         movf [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0; v1[m] = 0; v2[m] = 0; c1[m] = '0; c2[m] = '0;
      mqn[m] = 0; mbit[m] = 0; movf[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    int osr;
    bit drop;
    osr  = (m == 0) ? 8 : 4;
    drop = 0;
    if (mqn[m] > 0 && bit_ready) begin
      if (mbit[m] == 3) begin
        mqa[m][0] = mqa[m][1];
        mqn[m]--;
        mbit[m] = 0;
      end else begin
        mbit[m]++;
      end
    end
    if (v2[m]) begin
      if (mqn[m] < 2) begin
        mqa[m][mqn[m]] = c2[m];
        mqn[m]++;
      end else begin
        drop = 1;
      end
    end
    if (drop) movf[m] = 1;
    else if (ovf_clr) movf[m] = 0;
    v2[m] = v1[m];
    c2[m] = c1[m];
    v1[m] = din_valid && (mcnt[m] == int'(sample_phase));
    if (v1[m]) c1[m] = {slice(int'(din_i)), slice(int'(din_q))};
    if (din_valid) mcnt[m] = (mcnt[m] + 1) % osr;
  endtask

  always @(negedge CLK) begin
    logic [3:0] head;
    if (!Rst_n) model_reset();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("code_valid[%0d]", m), cv[m], v2[m]);
      if (v2[m]) check($sformatf("code_out[%0d]", m), code_o[m], c2[m]);
      check($sformatf("bit_valid[%0d]", m), bv[m], (mqn[m] > 0));
      if (mqn[m] > 0) begin
        head = mqa[m][0];
        check($sformatf("bit_out[%0d]", m), bo[m], head[3-mbit[m]]);
      end
      check($sformatf("overflow[%0d]", m), ov[m], movf[m]);
    end
    if (Rst_n) begin
      for (int m = 0; m < 2; m++) model_step(m);
    end
  end

  logic [3:0] got_code8 [$];
  bit         got_bit8 [$];
  bit         got_bit4 [$];

  always @(negedge CLK) begin
    if (Rst_n) begin
      if (cv[0]) got_code8.push_back(code_o[0]);
      if (bv[0] && bit_ready) got_bit8.push_back(bo[0]);
      if (bv[1] && bit_ready) got_bit4.push_back(bo[1]);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset(input logic [3:0] ph);
    Rst_n = 1'b0; din_valid = 1'b0; bit_ready = 1'b1; ovf_clr = 1'b0;
    din_i = '0; din_q = '0; sample_phase = ph;
    tick();
    tick();
    Rst_n = 1'b1;
    got_code8.delete();
    got_bit8.delete();
    got_bit4.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         first;
  logic [3:0] code;
  int         cnt;
  int         slice_in [7];
  logic [1:0] slice_exp [7];
  logic [3:0] e38 [5];
  int         i38 [5];
  int         q38 [5];
  logic [3:0] ecode;
  bit         bvh [64];

  initial begin
    Rst_n = 1'b0; din_valid = 1'b0; bit_ready = 1'b1; ovf_clr = 1'b0;
    din_i = '0; din_q = '0; sample_phase = 4'd3;
    #3;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_code_out[%0d]", m), code_o[m], 0);
      check($sformatf("rst_code_valid[%0d]", m), cv[m], 0);
      check($sformatf("rst_bit_valid[%0d]", m), bv[m], 0);
      check($sformatf("rst_bit_out[%0d]", m), bo[m], 0);
      check($sformatf("rst_overflow[%0d]", m), ov[m], 0);
    end

    // Basic decision: I=+6000 (+3 -> 10), Q=-100 (-1 -> 01)
    do_reset(4'd3);
    din_valid = 1'b1; din_i = 6000; din_q = -100;
    first = -1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (cv[0] && first < 0) begin
        first = t;
        code  = code_o[0];
      end
      if (t == 6) check("basic_bit0", bo[0], 1);
      if (t == 7) check("basic_bit1", bo[0], 0);
      if (t == 8) check("basic_bit2", bo[0], 0);
      if (t == 9) check("basic_bit3", bo[0], 1);
      if (t == 10) check("basic_idle_after", bv[0], 0);
    end
    check("basic_latency", first, 5);
    check("basic_code", code, 4'b1001);

    // Slicer boundaries on I, Q held at 0 (+1 -> 11)
    slice_in  = '{-4097, -4096, -1, 0, 4095, 4096, -262144};
    slice_exp = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00};
    do_reset(4'd3);
    din_valid = 1'b1; din_q = 0;
    for (int s = 0; s < 7; s++) begin
      din_i = 19'(slice_in[s]);
      repeat (8) tick();
    end
    din_valid = 1'b0;
    repeat (12) tick();
    check("slice_count", got_code8.size(), 7);
    for (int s = 0; s < 7 && s < got_code8.size(); s++) begin
      ecode = got_code8[s];
      check($sformatf("slice_i[%0d]", slice_in[s]), ecode[3:2], slice_exp[s]);
      check($sformatf("slice_q[%0d]", s), ecode[1:0], 2'b11);
    end

    // Backpressure: second code buffered, third dropped
    do_reset(4'd3);
    bit_ready = 1'b0;
    for (int t = 1; t <= 26; t++) begin
      din_valid = (t - 1) < 24;
      case ((t - 1) / 8)
        0:       begin din_i = 6000;  din_q = 6000;  end
        1:       begin din_i = -6000; din_q = -6000; end
        default: begin din_i = 100;   din_q = -100;  end
      endcase
      tick();
      if (t >= 6) begin
        check($sformatf("hold_valid_t%0d", t), bv[0], 1);
        check($sformatf("hold_bit_t%0d", t), bo[0], 1);
      end
      if (t == 21) check("ovf_before_drop", ov[0], 0);
      if (t == 23) check("ovf_after_drop", ov[0], 1);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", ov[0], 0);
    bit_ready = 1'b1;
    repeat (20) tick();
    check("hold_bit_count", got_bit8.size(), 8);
    for (int k = 0; k < 8 && k < got_bit8.size(); k++)
      check($sformatf("hold_stream[%0d]", k), got_bit8[k], (k < 4) ? ((k % 2) == 0) : 0);

    // OSR=4 back-to-back symbols, continuous output
    e38 = '{4'b1010, 4'b0001, 4'b1100, 4'b0111, 4'b1000};
    i38 = '{6000, -6000, 100, -100, 5000};
    q38 = '{6000, -100, -6000, 100, -5000};
    do_reset(4'd1);
    for (int t = 1; t <= 40; t++) begin
      din_valid = (t - 1) < 20;
      if ((t - 1) < 20) begin
        din_i = 19'(i38[(t - 1) / 4]);
        din_q = 19'(q38[(t - 1) / 4]);
      end
      tick();
      bvh[t] = bv[1];
    end
    first = -1;
    cnt   = 0;
    for (int t = 1; t <= 40; t++) begin
      if (bvh[t] && first < 0) first = t;
    end
    for (int t = first; t >= 1 && t <= 40 && bvh[t]; t++) cnt++;
    check("b2b_first_bit", first, 4);
    check("b2b_run_length", cnt, 20);
    check("b2b_bit_count", got_bit4.size(), 20);
    for (int k = 0; k < 20 && k < got_bit4.size(); k++) begin
      ecode = e38[k / 4];
      check($sformatf("b2b_stream[%0d]", k), got_bit4[k], ecode[3 - (k % 4)]);
    end
    check("b2b_overflow", ov[1], 0);

    // Out-of-range sample_phase never decides
    do_reset(4'd9);
    din_valid = 1'b1; din_i = 6000; din_q = 6000;
    cnt   = 0;
    first = 0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      cnt   += int'(cv[0]);
      first += int'(cv[1]);
    end
    check("phase9_osr8_codes", cnt, 0);
    check("phase9_osr4_codes", first, 0);

    // Reset mid-shift, then realignment from counter 0
    do_reset(4'd3);
    din_valid = 1'b1; din_i = 6000; din_q = -100;
    repeat (8) tick();
    check("pre_rst_shifting", bv[0], 1);
    Rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("midrst_code_out[%0d]", m), code_o[m], 0);
      check($sformatf("midrst_code_valid[%0d]", m), cv[m], 0);
      check($sformatf("midrst_bit_valid[%0d]", m), bv[m], 0);
      check($sformatf("midrst_bit_out[%0d]", m), bo[m], 0);
      check($sformatf("midrst_overflow[%0d]", m), ov[m], 0);
    end
    tick();
    tick();
    Rst_n = 1'b1;
    first = -1;
    for (int t = 1; t <= 30 && first < 0; t++) begin
      tick();
      if (cv[0]) begin
        first = t;
        code  = code_o[0];
      end
    end
    check("realign_latency", first, 5);
    check("realign_code", code, 4'b1001);
    din_valid = 1'b0;
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
